// File: rtl/pwm_decoder.sv
// pwm_decoder: measures high time and rise-to-rise period of an asynchronous PWM input,
// reporting decoded duty, period error and stuck-line detection.
module pwm_decoder #(
  parameter int CNT_W   = 8,
  parameter int PERIOD  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [3:0]       duty_cycle,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             valid,
  output logic             period_err,
  output logic             stuck
);
  typedef enum logic [1:0] {WAIT_RISE, HIGH, LOW} state_t;
  state_t state, state_n;
  logic s1, s2, s3;
  logic [2:0] warm;
  logic [CNT_W-1:0] cnt, high_reg, idle;
  logic rise, fall, upd, restart, latch_high, timeout;
  // s3 only holds a real sample three cycles after reset; a level already high
  // at reset would otherwise look like a rise and start a partial period.
  assign rise    = warm[2] & s2 & ~s3;
  assign fall    = warm[2] & ~s2 & s3;
  assign timeout = !rise && !fall && idle == CNT_W'(TIMEOUT - 1);
  always_comb begin
    state_n    = state;
    upd        = 1'b0;
    restart    = 1'b0;
    latch_high = 1'b0;
    case (state)
      WAIT_RISE: if (rise) begin state_n = HIGH; restart = 1'b1; end
      HIGH:      if (fall) begin state_n = LOW; latch_high = 1'b1; end
      LOW:       if (rise) begin state_n = HIGH; restart = 1'b1; upd = 1'b1; end
      default:   state_n = WAIT_RISE;
    endcase
    if (stuck) begin
      upd        = 1'b0;
      latch_high = 1'b0;
      restart    = rise;
      state_n    = rise ? HIGH : fall ? WAIT_RISE : state_n;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= WAIT_RISE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {s1, s2, s3} <= '0;
      warm         <= '0;
      cnt          <= '0;
      high_reg     <= '0;
      idle         <= '0;
      duty_cycle   <= '0;
      high_cnt     <= '0;
      period_cnt   <= '0;
      valid        <= 1'b0;
      period_err   <= 1'b0;
      stuck        <= 1'b0;
    end else begin
      {s1, s2, s3} <= {pwm_in, s1, s2};
      warm         <= {warm[1:0], 1'b1};
      cnt          <= restart ? CNT_W'(1) : (&cnt) ? cnt : cnt + 1'b1;
      if (latch_high) high_reg <= cnt;
      idle         <= (rise | fall) ? '0 : (idle == CNT_W'(TIMEOUT)) ? idle : idle + 1'b1;
      valid        <= upd | timeout;
      stuck        <= (rise | fall) ? 1'b0 : timeout ? 1'b1 : stuck;
      if (upd) begin
        period_cnt <= cnt;
        high_cnt   <= high_reg;
        duty_cycle <= (high_reg > CNT_W'(15)) ? 4'hf : high_reg[3:0];
        period_err <= cnt != CNT_W'(PERIOD);
      end else if (timeout) begin
        high_cnt   <= s2 ? period_cnt : '0;
        duty_cycle <= s2 ? 4'hf : 4'h0;
      end
    end
  end
endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: directed scenario tasks checking pwm_decoder against hand-computed values.
module tb_pwm_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwm_in = 1'b0;
  logic [3:0] duty_cycle;
  logic [7:0] high_cnt, period_cnt;
  logic valid, period_err, stuck;
  int errors = 0;
  int checks = 0;
  int nval = 0;
  longint last_t = 0, prev_t = 0;

  pwm_decoder #(.CNT_W(8), .PERIOD(16), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .duty_cycle(duty_cycle), .high_cnt(high_cnt),
    .period_cnt(period_cnt), .valid(valid), .period_err(period_err), .stuck(stuck)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (valid) begin
      nval++;
      prev_t = last_t;
      last_t = $time;
    end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic pwm_period(input int h, input int p);
    pwm_in = 1'b1;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (p - h) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (duty_cycle !== 4'd0) begin errors++; $display("FAIL reset_duty: got %0d expected 0", duty_cycle); end
    checks++; if (high_cnt !== 8'd0) begin errors++; $display("FAIL reset_high: got %0d expected 0", high_cnt); end
    checks++; if (period_cnt !== 8'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", period_cnt); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (period_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", period_err); end
    checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL reset_stuck: got %b expected 0", stuck); end
  endtask

  task automatic test_basic;
    int base;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    base = nval;
    repeat (4) pwm_period(5, 16);
    checks++; if (nval - base !== 3) begin errors++; $display("FAIL basic_count: got %0d expected 3", nval - base); end
    checks++; if (high_cnt !== 8'd5) begin errors++; $display("FAIL basic_high: got %0d expected 5", high_cnt); end
    checks++; if (period_cnt !== 8'd16) begin errors++; $display("FAIL basic_period: got %0d expected 16", period_cnt); end
    checks++; if (duty_cycle !== 4'd5) begin errors++; $display("FAIL basic_duty: got %0d expected 5", duty_cycle); end
    checks++; if (period_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", period_err); end
    checks++; if (last_t - prev_t !== 64'd160) begin errors++; $display("FAIL basic_spacing: got %0d expected 160", last_t - prev_t); end
  endtask

  task automatic test_duty_change;
    repeat (2) pwm_period(15, 16);
    checks++; if (duty_cycle !== 4'd15) begin errors++; $display("FAIL duty15: got %0d expected 15", duty_cycle); end
    checks++; if (high_cnt !== 8'd15) begin errors++; $display("FAIL duty15_high: got %0d expected 15", high_cnt); end
    pwm_period(1, 16);
    checks++; if (duty_cycle !== 4'd15) begin errors++; $display("FAIL duty_lag: got %0d expected 15", duty_cycle); end
    pwm_period(1, 16);
    checks++; if (duty_cycle !== 4'd1) begin errors++; $display("FAIL duty1: got %0d expected 1", duty_cycle); end
    checks++; if (high_cnt !== 8'd1) begin errors++; $display("FAIL duty1_high: got %0d expected 1", high_cnt); end
  endtask

  task automatic test_period_err;
    repeat (2) pwm_period(8, 20);
    checks++; if (period_cnt !== 8'd20) begin errors++; $display("FAIL perr_period: got %0d expected 20", period_cnt); end
    checks++; if (high_cnt !== 8'd8) begin errors++; $display("FAIL perr_high: got %0d expected 8", high_cnt); end
    checks++; if (duty_cycle !== 4'd8) begin errors++; $display("FAIL perr_duty: got %0d expected 8", duty_cycle); end
    checks++; if (period_err !== 1'b1) begin errors++; $display("FAIL perr_set: got %b expected 1", period_err); end
    repeat (2) pwm_period(5, 16);
    checks++; if (period_err !== 1'b0) begin errors++; $display("FAIL perr_clear: got %b expected 0", period_err); end
    checks++; if (period_cnt !== 8'd16) begin errors++; $display("FAIL perr_period16: got %0d expected 16", period_cnt); end
  endtask

  task automatic test_stuck_low;
    int base;
    base = nval;
    pwm_in = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (nval - base !== 1) begin errors++; $display("FAIL low_count: got %0d expected 1", nval - base); end
    checks++; if (stuck !== 1'b1) begin errors++; $display("FAIL low_stuck: got %b expected 1", stuck); end
    checks++; if (duty_cycle !== 4'd0) begin errors++; $display("FAIL low_duty: got %0d expected 0", duty_cycle); end
    checks++; if (high_cnt !== 8'd0) begin errors++; $display("FAIL low_high: got %0d expected 0", high_cnt); end
    checks++; if (period_cnt !== 8'd16) begin errors++; $display("FAIL low_period: got %0d expected 16", period_cnt); end
    checks++; if (period_err !== 1'b0) begin errors++; $display("FAIL low_err: got %b expected 0", period_err); end
  endtask

  task automatic test_stuck_high;
    int base;
    base = nval;
    pwm_in = 1'b1;
    repeat (100) @(negedge clk);
    checks++; if (nval - base !== 1) begin errors++; $display("FAIL high_count: got %0d expected 1", nval - base); end
    checks++; if (stuck !== 1'b1) begin errors++; $display("FAIL high_stuck: got %b expected 1", stuck); end
    checks++; if (duty_cycle !== 4'd15) begin errors++; $display("FAIL high_duty: got %0d expected 15", duty_cycle); end
    checks++; if (high_cnt !== 8'd16) begin errors++; $display("FAIL high_high: got %0d expected 16", high_cnt); end
    base = nval;
    pwm_period(8, 16);
    checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL resume_stuck: got %b expected 0", stuck); end
    repeat (2) pwm_period(8, 16);
    checks++; if (nval - base !== 1) begin errors++; $display("FAIL resume_count: got %0d expected 1", nval - base); end
    checks++; if (duty_cycle !== 4'd8) begin errors++; $display("FAIL resume_duty: got %0d expected 8", duty_cycle); end
    checks++; if (period_cnt !== 8'd16) begin errors++; $display("FAIL resume_period: got %0d expected 16", period_cnt); end
  endtask

  task automatic test_reset_mid;
    int base;
    pwm_in = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (duty_cycle !== 4'd0) begin errors++; $display("FAIL mid_duty: got %0d expected 0", duty_cycle); end
    checks++; if (high_cnt !== 8'd0) begin errors++; $display("FAIL mid_high: got %0d expected 0", high_cnt); end
    checks++; if (period_cnt !== 8'd0) begin errors++; $display("FAIL mid_period: got %0d expected 0", period_cnt); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", valid); end
    checks++; if (period_err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b expected 0", period_err); end
    checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL mid_stuck: got %b expected 0", stuck); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base = nval;
    repeat (2) @(negedge clk);
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    pwm_period(5, 16);
    checks++; if (nval - base !== 0) begin errors++; $display("FAIL mid_early: got %0d expected 0", nval - base); end
    pwm_period(5, 16);
    checks++; if (nval - base !== 1) begin errors++; $display("FAIL mid_count: got %0d expected 1", nval - base); end
    checks++; if (high_cnt !== 8'd5) begin errors++; $display("FAIL mid_high5: got %0d expected 5", high_cnt); end
    checks++; if (period_cnt !== 8'd16) begin errors++; $display("FAIL mid_period16: got %0d expected 16", period_cnt); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_duty_change;
    test_period_err;
    test_stuck_low;
    test_stuck_high;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
